// File: rtl/ga_pkg.sv
// Shared types and default sizing for the genetic-algorithm selection pipeline.
package ga_pkg;

    localparam int DEF_POP_SIZE      = 32;
    localparam int DEF_CHROM_WIDTH   = 16;
    localparam int DEF_FITNESS_WIDTH = (DEF_CHROM_WIDTH + 1) * 3;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

endpackage

// File: rtl/fit_cmp.sv
// Two-input winner selection: lower fitness wins, ties go to input b.
module fit_cmp #(
    parameter int CHROM_WIDTH   = 16,
    parameter int FITNESS_WIDTH = 51
) (
    input  logic [CHROM_WIDTH-1:0]   chrom_a,
    input  logic [FITNESS_WIDTH-1:0] fit_a,
    input  logic [CHROM_WIDTH-1:0]   chrom_b,
    input  logic [FITNESS_WIDTH-1:0] fit_b,
    output logic [CHROM_WIDTH-1:0]   chrom_win,
    output logic [FITNESS_WIDTH-1:0] fit_win
);

    logic a_wins;

    // Full-width unsigned compare; strict so that equal fitness keeps b.
    assign a_wins    = (fit_a < fit_b);
    assign chrom_win = a_wins ? chrom_a : chrom_b;
    assign fit_win   = a_wins ? fit_a   : fit_b;

endmodule

// File: rtl/tournament_sel.sv
// Tournament selection: collects pair winners into a pool, then emits them
// downstream as parent pairs while tracking the best chromosome seen.
module tournament_sel
    import ga_pkg::*;
#(
    parameter int POP_SIZE      = DEF_POP_SIZE,
    parameter int CHROM_WIDTH   = DEF_CHROM_WIDTH,
    parameter int FITNESS_WIDTH = (CHROM_WIDTH + 1) * 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [CHROM_WIDTH-1:0]   in_chrom1,
    input  logic [CHROM_WIDTH-1:0]   in_chrom2,
    input  logic [FITNESS_WIDTH-1:0] in_fit1,
    input  logic [FITNESS_WIDTH-1:0] in_fit2,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [CHROM_WIDTH-1:0]   out_parent1,
    output logic [CHROM_WIDTH-1:0]   out_parent2,
    input  logic                     out_ready,
    output logic [CHROM_WIDTH-1:0]   best,
    output logic [FITNESS_WIDTH-1:0] best_fit,
    output logic                     gen_done,
    output logic [15:0]              gen_count
);

    localparam int DEPTH = POP_SIZE / 2;
    localparam int PAIRS = POP_SIZE / 4;
    localparam int WR_W  = $clog2(DEPTH);
    localparam int RD_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    state_t                   state, state_next;
    logic [WR_W-1:0]          wr_idx;
    logic [RD_W-1:0]          rd_idx;
    logic [CHROM_WIDTH-1:0]   pool [DEPTH];
    logic [WR_W-1:0]          addr0, addr1;

    logic                     accept, handshake, last_accept, last_pair;
    logic [CHROM_WIDTH-1:0]   win_chrom, best_chrom_next;
    logic [FITNESS_WIDTH-1:0] win_fit, best_fit_next;

    fit_cmp #(
        .CHROM_WIDTH  (CHROM_WIDTH),
        .FITNESS_WIDTH(FITNESS_WIDTH)
    ) u_pair_cmp (
        .chrom_a  (in_chrom1),
        .fit_a    (in_fit1),
        .chrom_b  (in_chrom2),
        .fit_b    (in_fit2),
        .chrom_win(win_chrom),
        .fit_win  (win_fit)
    );

    // Current best sits on input b, so a tie keeps the incumbent.
    fit_cmp #(
        .CHROM_WIDTH  (CHROM_WIDTH),
        .FITNESS_WIDTH(FITNESS_WIDTH)
    ) u_best_cmp (
        .chrom_a  (win_chrom),
        .fit_a    (win_fit),
        .chrom_b  (best),
        .fit_b    (best_fit),
        .chrom_win(best_chrom_next),
        .fit_win  (best_fit_next)
    );

    assign in_ready    = (state == COLLECT);
    assign out_valid   = (state == EMIT);
    assign accept      = in_valid && in_ready;
    assign handshake   = out_valid && out_ready;
    assign last_accept = accept && (wr_idx == WR_W'(DEPTH - 1));
    assign last_pair   = handshake && (rd_idx == RD_W'(PAIRS - 1));

    assign addr0       = WR_W'({rd_idx, 1'b0});
    assign addr1       = addr0 | WR_W'(1);
    assign out_parent1 = out_valid ? pool[addr0] : '0;
    assign out_parent2 = out_valid ? pool[addr1] : '0;

    // NOTE: non-blocking assignments for every register so all state
    // updates see the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= COLLECT;
        else        state <= state_next;
    end

    // NOTE: default assigned first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (last_accept) state_next = EMIT;
            EMIT:    if (last_pair)   state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            best      <= '0;
            best_fit  <= '1;
            gen_done  <= 1'b0;
            gen_count <= '0;
        end else begin
            gen_done <= last_pair;
            if (accept) begin
                wr_idx   <= last_accept ? '0 : wr_idx + WR_W'(1);
                best     <= best_chrom_next;
                best_fit <= best_fit_next;
                if (last_accept) rd_idx <= '0;
            end
            if (handshake) begin
                rd_idx <= last_pair ? '0 : rd_idx + RD_W'(1);
                if (last_pair) gen_count <= gen_count + 16'd1;
            end
        end
    end

    // NOTE: the pool is plain storage with no reset; it is only read in EMIT,
    // after a full generation has overwritten every entry.
    always_ff @(posedge clk) begin
        if (accept) pool[wr_idx] <= win_chrom;
    end

endmodule

// File: tb/tb_tournament_sel.sv
// Self-checking bench for tournament_sel: directed scenarios plus random
// traffic, all checked each cycle against a queue-based behavioural model.
module tb_tournament_sel;

    localparam int POP  = 8;
    localparam int CW   = 16;
    localparam int FW   = (CW + 1) * 3;
    localparam int NPRS = POP / 4;
    localparam int NWIN = POP / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [CW-1:0] in_chrom1, in_chrom2;
    logic [FW-1:0] in_fit1, in_fit2;
    logic          in_ready, out_valid, out_ready, gen_done;
    logic [CW-1:0] out_parent1, out_parent2, best;
    logic [FW-1:0] best_fit;
    logic [15:0]   gen_count;

    int n_checks = 0;
    int n_pass   = 0;

    tournament_sel #(
        .POP_SIZE   (POP),
        .CHROM_WIDTH(CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_chrom1  (in_chrom1),
        .in_chrom2  (in_chrom2),
        .in_fit1    (in_fit1),
        .in_fit2    (in_fit2),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_parent1(out_parent1),
        .out_parent2(out_parent2),
        .out_ready  (out_ready),
        .best       (best),
        .best_fit   (best_fit),
        .gen_done   (gen_done),
        .gen_count  (gen_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: list of winners this generation, pairs consumed.
    bit            m_emit;
    logic [CW-1:0] m_pool[$];
    int            m_pair;
    logic [CW-1:0] m_best;
    logic [FW-1:0] m_best_fit;
    bit            m_gen_done;
    int            m_gen_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_emit      = 1'b0;
        m_pool.delete();
        m_pair      = 0;
        m_best      = '0;
        m_best_fit  = '1;
        m_gen_done  = 1'b0;
        m_gen_count = 0;
    endtask

    task automatic model_step();
        logic [CW-1:0] w;
        logic [FW-1:0] wf;
        if (!reset) begin
            model_reset();
            return;
        end
        m_gen_done = 1'b0;
        if (!m_emit) begin
            if (in_valid) begin
                if (in_fit1 < in_fit2) begin w = in_chrom1; wf = in_fit1; end
                else                   begin w = in_chrom2; wf = in_fit2; end
                m_pool.push_back(w);
                if (wf < m_best_fit) begin m_best = w; m_best_fit = wf; end
                if (m_pool.size() == NWIN) begin m_emit = 1'b1; m_pair = 0; end
            end
        end else if (out_ready) begin
            m_pair++;
            if (m_pair == NPRS) begin
                m_emit = 1'b0;
                m_pool.delete();
                m_gen_done = 1'b1;
                m_gen_count++;
            end
        end
    endtask

    task automatic compare();
        logic [CW-1:0] p1, p2;
        p1 = m_emit ? m_pool[2*m_pair]   : '0;
        p2 = m_emit ? m_pool[2*m_pair+1] : '0;
        check("in_ready",    64'(in_ready),    64'(!m_emit));
        check("out_valid",   64'(out_valid),   64'(m_emit));
        check("out_parent1", 64'(out_parent1), 64'(p1));
        check("out_parent2", 64'(out_parent2), 64'(p2));
        check("best",        64'(best),        64'(m_best));
        check("best_fit",    64'(best_fit),    64'(m_best_fit));
        check("gen_done",    64'(gen_done),    64'(m_gen_done));
        check("gen_count",   64'(gen_count),   64'(m_gen_count[15:0]));
    endtask

    // One clock: inputs held across the rising edge, outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic send(input logic [CW-1:0] c1, input logic [FW-1:0] f1,
                        input logic [CW-1:0] c2, input logic [FW-1:0] f2);
        in_valid  = 1'b1;
        in_chrom1 = c1; in_fit1 = f1;
        in_chrom2 = c2; in_fit2 = f2;
        cycle();
        in_valid  = 1'b0;
    endtask

    function automatic logic [FW-1:0] rand_fit();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 2))
            0:       return FW'($urandom_range(0, 7));
            1:       return r[FW-1:0];
            default: return {1'b1, {(FW-4){1'b0}}, 3'($urandom_range(0, 7))};
        endcase
    endfunction

    initial begin
        logic [CW-1:0] held1, held2;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_chrom1 = '0; in_chrom2 = '0; in_fit1 = '0; in_fit2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        check("rst_best_fit_ones", 64'(best_fit), 64'({FW{1'b1}}));
        reset = 1'b1;

        // Tie handling and full generation with out_ready held high.
        out_ready = 1'b1;
        send(16'h1111, 5, 16'h2222, 5);
        check("tie_best", 64'(best), 64'h2222);
        check("tie_best_fit", 64'(best_fit), 64'd5);
        send(16'h3333, 2, 16'h4444, 8);
        send(16'h5555, 9, 16'h6666, 1);
        send(16'h7777, 0, 16'h8888, 0);
        check("gen_first_valid", 64'(out_valid), 64'd1);
        check("gen_pair0_p1", 64'(out_parent1), 64'h2222);
        check("gen_pair0_p2", 64'(out_parent2), 64'h3333);
        cycle();
        check("gen_pair1_p1", 64'(out_parent1), 64'h6666);
        check("gen_pair1_p2", 64'(out_parent2), 64'h8888);
        cycle();
        check("gen_done_pulse", 64'(gen_done), 64'd1);
        check("gen_count_one", 64'(gen_count), 64'd1);
        check("ready_after_final", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        cycle();
        check("gen_done_drop", 64'(gen_done), 64'd0);

        // Backpressure with in_valid asserted during EMIT.
        for (int i = 0; i < NWIN; i++)
            send(16'(16'h0100 + i), FW'(i + 20), 16'(16'h0200 + i), FW'(40 - i));
        held1 = out_parent1; held2 = out_parent2;
        check("bp_p1_first", 64'(held1), 64'h0100);
        in_valid = 1'b1; in_chrom1 = 16'hDEAD; in_fit1 = '0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_p1_stable", 64'(out_parent1), 64'(held1));
            check("bp_p2_stable", 64'(out_parent2), 64'(held2));
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) cycle();
        out_ready = 1'b0;

        // Asynchronous reset partway through a generation.
        send(16'hAAAA, 4, 16'hBBBB, 6);
        send(16'hCCCC, 1, 16'hDDDD, 6);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_best", 64'(best), 64'd0);
        check("arst_gen_count", 64'(gen_count), 64'd0);
        compare();
        cycle();
        reset = 1'b1;

        // Best tracking over winners with fitness 9,3,7,3.
        send(16'hA009, 9,  16'hFFFF, 20);
        send(16'h0001, 30, 16'hB003, 3);
        send(16'hC007, 7,  16'h0002, 8);
        send(16'h0004, 5,  16'hD003, 3);
        check("bt_best", 64'(best), 64'hB003);
        check("bt_best_fit", 64'(best_fit), 64'd3);
        check("bt_pool0_after_reset", 64'(out_parent1), 64'hA009);
        out_ready = 1'b1;
        repeat (3) cycle();
        check("bt_gen_count", 64'(gen_count), 64'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_chrom1 = CW'($urandom);
            in_chrom2 = CW'($urandom);
            in_fit1   = rand_fit();
            in_fit2   = ($urandom_range(0, 4) == 0) ? in_fit1 : rand_fit();
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
